// File: rtl/mac_sequencer_pkg.sv
// Shared fixed-point format and FSM state type for the MAC sequencer.
package mac_sequencer_pkg;

   localparam int unsigned Q_INT  = 8;
   localparam int unsigned Q_FRAC = 8;
   localparam int unsigned Q_SIZE = Q_INT + Q_FRAC;

   typedef logic [Q_INT-1:-Q_FRAC] q_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StBias
   } mac_seq_state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Drives one MacUnit through a dot product: issues operand RAM reads, steers the
// returned data into the MAC, and captures the accumulated result (plus optional bias).
module mac_sequencer
   import mac_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LEN_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] x_base,
   input  logic [ADDR_W-1:0] w_base,
   input  logic              use_bias,
   input  logic [Q_SIZE-1:0] bias,
   output logic              busy,
   output logic              done,
   output logic [Q_SIZE-1:0] result,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] x_addr,
   output logic [ADDR_W-1:0] w_addr,
   input  logic [Q_SIZE-1:0] x_data,
   input  logic [Q_SIZE-1:0] w_data,
   output logic [Q_SIZE-1:0] mac_x,
   output logic [Q_SIZE-1:0] mac_w,
   output logic              mac_reg_enable,
   output logic              mac_x_select,
   output logic              mac_w_select,
   output logic              mac_acc_loopback,
   input  logic [Q_SIZE-1:0] mac_in
);

   mac_seq_state_t   state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic             use_bias_q;
   q_t               bias_q;
   q_t               held_q;
   logic             i_first;
   logic             i_last;
   logic             d_v;
   logic             d_first;
   logic             d_last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= StIdle;
         len_q      <= '0;
         cnt        <= '0;
         use_bias_q <= 1'b0;
         bias_q     <= '0;
         held_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         mem_rd_en  <= 1'b0;
         x_addr     <= '0;
         w_addr     <= '0;
         i_first    <= 1'b0;
         i_last     <= 1'b0;
         d_v        <= 1'b0;
         d_first    <= 1'b0;
         d_last     <= 1'b0;
      end else begin
         done    <= 1'b0;
         d_v     <= mem_rd_en;
         d_first <= i_first;
         d_last  <= i_last;
         if (done) begin
            busy <= 1'b0;
         end

         // Final product lands on the last data cycle; bias runs take one extra add cycle.
         if (d_v && d_last) begin
            if (use_bias_q) begin
               held_q <= mac_in;
            end else begin
               result <= mac_in;
               done   <= 1'b1;
            end
         end

         unique case (state)
            StIdle: begin
               // The done cycle still counts as busy, so a start there is dropped.
               if (start && !done) begin
                  len_q      <= len;
                  use_bias_q <= use_bias;
                  bias_q     <= use_bias ? bias : '0;
                  held_q     <= '0;
                  busy       <= 1'b1;
                  if (len != '0) begin
                     state     <= StIssue;
                     mem_rd_en <= 1'b1;
                     x_addr    <= x_base;
                     w_addr    <= w_base;
                     cnt       <= LEN_W'(1);
                     i_first   <= 1'b1;
                     i_last    <= (len == LEN_W'(1));
                  end else begin
                     state <= StBias;
                  end
               end
            end
            StIssue: begin
               i_first <= 1'b0;
               if (i_last) begin
                  state     <= StDrain;
                  mem_rd_en <= 1'b0;
                  i_last    <= 1'b0;
               end else begin
                  x_addr <= x_addr + 1'b1;
                  w_addr <= w_addr + 1'b1;
                  cnt    <= cnt + 1'b1;
                  i_last <= ((cnt + 1'b1) == len_q);
               end
            end
            StDrain: begin
               state <= use_bias_q ? StBias : StIdle;
            end
            StBias: begin
               result <= held_q + bias_q;
               done   <= 1'b1;
               state  <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

   assign mac_x            = d_v ? x_data : '0;
   assign mac_w            = d_v ? w_data : '0;
   assign mac_x_select     = d_v;
   assign mac_w_select     = d_v;
   assign mac_acc_loopback = d_v & ~d_first;
   assign mac_reg_enable   = 1'b0;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with behavioural operand RAMs and a MacUnit model;
// expected reads, MAC steering and results are queued at start and retired as seen.
module tb_mac_sequencer;
   import mac_sequencer_pkg::*;

   localparam int unsigned AW = 10;
   localparam int unsigned LW = 10;
   localparam int unsigned QS = Q_SIZE;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [LW-1:0] len;
   logic [AW-1:0] x_base;
   logic [AW-1:0] w_base;
   logic          use_bias;
   logic [QS-1:0] bias;
   logic          busy;
   logic          done;
   logic [QS-1:0] result;
   logic          mem_rd_en;
   logic [AW-1:0] x_addr;
   logic [AW-1:0] w_addr;
   logic [QS-1:0] x_data;
   logic [QS-1:0] w_data;
   logic [QS-1:0] mac_x;
   logic [QS-1:0] mac_w;
   logic          mac_reg_enable;
   logic          mac_x_select;
   logic          mac_w_select;
   logic          mac_acc_loopback;
   logic [QS-1:0] mac_in;

   mac_sequencer #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .len              (len),
      .x_base           (x_base),
      .w_base           (w_base),
      .use_bias         (use_bias),
      .bias             (bias),
      .busy             (busy),
      .done             (done),
      .result           (result),
      .mem_rd_en        (mem_rd_en),
      .x_addr           (x_addr),
      .w_addr           (w_addr),
      .x_data           (x_data),
      .w_data           (w_data),
      .mac_x            (mac_x),
      .mac_w            (mac_w),
      .mac_reg_enable   (mac_reg_enable),
      .mac_x_select     (mac_x_select),
      .mac_w_select     (mac_w_select),
      .mac_acc_loopback (mac_acc_loopback),
      .mac_in           (mac_in)
   );

   always #5 clk = ~clk;

   logic [QS-1:0] xmem [1024];
   logic [QS-1:0] wmem [1024];
   logic [QS-1:0] acc_q;
   logic [2*QS-1:0] prod;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         x_data <= xmem[x_addr];
         w_data <= wmem[w_addr];
      end
   end

   // MacUnit model: product plus accumulator masked by loopback; accumulator tracks output.
   always_comb begin
      prod   = (mac_x_select ? mac_x : '0) * (mac_w_select ? mac_w : '0);
      mac_in = prod[QS-1:0] + (mac_acc_loopback ? acc_q : '0);
   end

   always @(posedge clk) begin
      if (!reset) acc_q <= '0;
      else        acc_q <= mac_in;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   typedef struct {logic [AW-1:0] xa; logic [AW-1:0] wa; int cyc;} addr_exp_t;
   typedef struct {logic lb; logic [QS-1:0] xv; logic [QS-1:0] wv; int cyc;} data_exp_t;
   typedef struct {logic [QS-1:0] res; int cyc;} res_exp_t;

   addr_exp_t aq[$];
   data_exp_t dq[$];
   res_exp_t  rq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   addr_exp_t a_e;
   data_exp_t d_e;
   res_exp_t  r_e;

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_rd_en) begin
            if (aq.size() == 0) begin
               check("unexpected_read", 1, 0);
            end else begin
               a_e = aq.pop_front();
               check("x_addr", 32'(x_addr), 32'(a_e.xa));
               check("w_addr", 32'(w_addr), 32'(a_e.wa));
               check("read_cycle", cyc, a_e.cyc);
               check("busy_during_issue", 32'(busy), 1);
            end
         end
         if (mac_x_select) begin
            if (dq.size() == 0) begin
               check("unexpected_data_cycle", 1, 0);
            end else begin
               d_e = dq.pop_front();
               check("loopback", 32'(mac_acc_loopback), 32'(d_e.lb));
               check("mac_x", 32'(mac_x), 32'(d_e.xv));
               check("mac_w", 32'(mac_w), 32'(d_e.wv));
               check("mac_w_select", 32'(mac_w_select), 1);
               check("data_cycle", cyc, d_e.cyc);
            end
         end
         if (done) begin
            if (rq.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               r_e = rq.pop_front();
               check("result", 32'(result), 32'(r_e.res));
               check("done_cycle", cyc, r_e.cyc);
               check("busy_in_done", 32'(busy), 1);
            end
         end
         if (mac_reg_enable) check("mac_reg_enable", 32'(mac_reg_enable), 0);
      end
   end

   // e is the bench cycle number right after the accepting edge (cycle 1 of the run).
   task automatic push_expect(input int n, input int xb, input int wb, input bit ub,
                              input logic [QS-1:0] res, input int e);
      for (int i = 0; i < n; i++) begin
         aq.push_back('{xa: AW'(xb + i), wa: AW'(wb + i), cyc: e + i});
         dq.push_back('{lb: (i != 0), xv: xmem[(xb + i) % 1024], wv: wmem[(wb + i) % 1024],
                        cyc: e + i + 1});
      end
      rq.push_back('{res: res, cyc: (n == 0) ? e + 1 : e + n + 1 + int'(ub)});
   endtask

   task automatic drive(input int n, input int xb, input int wb, input bit ub,
                        input logic [QS-1:0] b);
      start    = 1'b1;
      len      = LW'(n);
      x_base   = AW'(xb);
      w_base   = AW'(wb);
      use_bias = ub;
      bias     = b;
   endtask

   task automatic start_op(input int n, input int xb, input int wb, input bit ub,
                           input logic [QS-1:0] b, input logic [QS-1:0] res);
      @(posedge clk); #1;
      drive(n, xb, wb, ub, b);
      @(posedge clk); #1;
      start = 1'b0;
      push_expect(n, xb, wb, ub, res, cyc);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rq.size() != 0 || busy) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("completion_in_time", 32'(n < 300), 1);
      check("reads_and_data_retired", aq.size() + dq.size(), 0);
      check("idle_not_busy", 32'(busy), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_x_addr"}, 32'(x_addr), 0);
      check({tag, "_w_addr"}, 32'(w_addr), 0);
      check({tag, "_mac_x"}, 32'(mac_x), 0);
      check({tag, "_x_sel"}, 32'(mac_x_select), 0);
      check({tag, "_loopback"}, 32'(mac_acc_loopback), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit seen_done;
      bit seen_rd;
      for (int i = 0; i < 1024; i++) begin
         xmem[i] = '0;
         wmem[i] = '0;
      end
      reset = 1'b0;
      drive(0, 0, 0, 1'b0, '0);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      reset  = 1'b1;
      mon_en = 1'b1;

      xmem[10'h100] = 16'd1; xmem[10'h101] = 16'd2; xmem[10'h102] = 16'd3;
      wmem[10'h200] = 16'd4; wmem[10'h201] = 16'd5; wmem[10'h202] = 16'd6;
      start_op(3, 'h100, 'h200, 1'b0, 16'd0, 16'd32);
      wait_idle();
      start_op(3, 'h100, 'h200, 1'b1, 16'd10, 16'd42);
      wait_idle();

      start_op(0, 'h100, 'h200, 1'b1, 16'd7, 16'd7);
      wait_idle();
      start_op(0, 'h100, 'h200, 1'b0, 16'd7, 16'd0);
      wait_idle();

      xmem[10'h3FF] = 16'hFFFF;
      wmem[10'h010] = 16'd2;
      start_op(1, 'h3FF, 'h010, 1'b0, 16'd0, 16'hFFFE);
      wait_idle();

      // Address wrap on both vectors: -1*5 + 3*7 = 16.
      xmem[10'h000] = 16'd3;
      wmem[10'h3FE] = 16'd5;
      wmem[10'h3FF] = 16'd7;
      start_op(2, 'h3FF, 'h3FE, 1'b0, 16'd0, 16'h0010);
      wait_idle();

      // Start while busy, then in the done cycle: both ignored; the next-cycle start runs.
      start_op(3, 'h100, 'h200, 1'b0, 16'd0, 16'd32);
      drive(7, 'h000, 'h000, 1'b1, 16'h0055);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen_before_restart", 32'(done), 1);
      drive(3, 'h100, 'h200, 1'b1, 16'd10);
      @(posedge clk); #1;
      check("start_in_done_cycle_ignored", 32'(busy), 0);
      @(posedge clk); #1;
      start = 1'b0;
      push_expect(3, 'h100, 'h200, 1'b1, 16'd42, cyc);
      check("result_held_until_next_done", 32'(result), 32);
      wait_idle();

      // Reset mid-issue aborts with no done.
      mon_en = 1'b0;
      @(posedge clk); #1;
      drive(5, 'h050, 'h060, 1'b0, 16'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check_zero_outputs("abort");
      seen_done = 1'b0;
      seen_rd   = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         seen_done |= done;
         seen_rd   |= mem_rd_en;
      end
      check("abort_no_done", 32'(seen_done), 0);
      check("abort_no_reads", 32'(seen_rd), 0);
      mon_en = 1'b1;

      xmem[10'h300] = 16'd1; xmem[10'h301] = 16'd1;
      wmem[10'h310] = 16'd1; wmem[10'h311] = 16'd1;
      start_op(2, 'h300, 'h310, 1'b0, 16'd0, 16'd2);
      wait_idle();

      check("scoreboard_empty", rq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
